// File: rtl/tec8_datapath.sv
// TEC-8 datapath: register file, 74181-style ALU, PC/AR/IR, flags, internal RAM and the
// W1-W3 beat sequencer, all driven by the controller's control word and committed on T3.
module tec8_datapath #(
    parameter int unsigned AW   = 8,
    parameter string       INIT = ""
) (
    input  logic          T3,
    input  logic          CLR,
    input  logic          START,
    input  logic [7:0]    SD,
    input  logic          SELCTL,
    input  logic          DRW,
    input  logic          LPC,
    input  logic          PCINC,
    input  logic          PCADD,
    input  logic          LAR,
    input  logic          ARINC,
    input  logic          LIR,
    input  logic          LDZ,
    input  logic          LDC,
    input  logic          CIN,
    input  logic          M,
    input  logic          MEMW,
    input  logic          ABUS,
    input  logic          SBUS,
    input  logic          MBUS,
    input  logic          STOP,
    input  logic          SHORT,
    input  logic          LONG,
    input  logic [3:0]    S,
    input  logic [3:0]    SEL,
    output logic [3:0]    IR,
    output logic          C,
    output logic          Z,
    output logic [3:1]    W,
    output logic [7:0]    DBUS,
    output logic [AW-1:0] PC_O,
    output logic [AW-1:0] AR_O,
    output logic          RUN,
    output logic          BUS_ERR
);

    localparam logic [2:0] W1 = 3'b001;
    localparam logic [2:0] W2 = 3'b010;
    localparam logic [2:0] W3 = 3'b100;

    logic [7:0]    rf_q [4];
    logic [7:0]    rf_d [4];
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ar_q, ar_d;
    logic [7:0]    ir_q, ir_d;
    logic          c_q, c_d;
    logic          z_q, z_d;
    logic [2:0]    w_q, w_d;
    logic          run_q, run_d;
    logic          be_q, be_d;

    logic [7:0]    mem_q [2**AW];

    logic [1:0]    sel_a, sel_b;
    logic [7:0]    alu_a, alu_b;
    logic [7:0]    arith_x, arith_y;
    logic [8:0]    arith_sum;
    logic [7:0]    logic_f;
    logic [7:0]    alu_f;
    logic          alu_cout;
    logic [7:0]    dbus;
    logic          multi_bus;

    assign sel_a = SELCTL ? SEL[3:2] : ir_q[3:2];
    assign sel_b = SELCTL ? SEL[1:0] : ir_q[1:0];
    assign alu_a = rf_q[sel_a];
    assign alu_b = rf_q[sel_b];

    // Arithmetic mode is expressed as x + y + carry; "minus 1" terms use y = 8'hFF.
    always_comb begin
        arith_x = alu_a;
        arith_y = 8'h00;
        unique case (S)
            4'b0000: begin arith_x = alu_a;           arith_y = 8'h00;           end
            4'b0001: begin arith_x = alu_a | alu_b;   arith_y = 8'h00;           end
            4'b0010: begin arith_x = alu_a | ~alu_b;  arith_y = 8'h00;           end
            4'b0011: begin arith_x = 8'h00;           arith_y = 8'hFF;           end
            4'b0100: begin arith_x = alu_a;           arith_y = alu_a & ~alu_b;  end
            4'b0101: begin arith_x = alu_a | alu_b;   arith_y = alu_a & ~alu_b;  end
            4'b0110: begin arith_x = alu_a;           arith_y = ~alu_b;          end
            4'b0111: begin arith_x = alu_a & ~alu_b;  arith_y = 8'hFF;           end
            4'b1000: begin arith_x = alu_a;           arith_y = alu_a & alu_b;   end
            4'b1001: begin arith_x = alu_a;           arith_y = alu_b;           end
            4'b1010: begin arith_x = alu_a | ~alu_b;  arith_y = alu_a & alu_b;   end
            4'b1011: begin arith_x = alu_a & alu_b;   arith_y = 8'hFF;           end
            4'b1100: begin arith_x = alu_a;           arith_y = alu_a;           end
            4'b1101: begin arith_x = alu_a | alu_b;   arith_y = alu_a;           end
            4'b1110: begin arith_x = alu_a | ~alu_b;  arith_y = alu_a;           end
            default: begin arith_x = alu_a;           arith_y = 8'hFF;           end
        endcase
    end

    assign arith_sum = {1'b0, arith_x} + {1'b0, arith_y} + {8'h00, ~CIN};

    always_comb begin
        logic_f = 8'h00;
        unique case (S)
            4'b0000: logic_f = ~alu_a;
            4'b0001: logic_f = ~(alu_a | alu_b);
            4'b0010: logic_f = ~alu_a & alu_b;
            4'b0011: logic_f = 8'h00;
            4'b0100: logic_f = ~(alu_a & alu_b);
            4'b0101: logic_f = ~alu_b;
            4'b0110: logic_f = alu_a ^ alu_b;
            4'b0111: logic_f = alu_a & ~alu_b;
            4'b1000: logic_f = ~alu_a | alu_b;
            4'b1001: logic_f = ~(alu_a ^ alu_b);
            4'b1010: logic_f = alu_b;
            4'b1011: logic_f = alu_a & alu_b;
            4'b1100: logic_f = 8'hFF;
            4'b1101: logic_f = alu_a | ~alu_b;
            4'b1110: logic_f = alu_a | alu_b;
            default: logic_f = alu_a;
        endcase
    end

    assign alu_f    = M ? logic_f : arith_sum[7:0];
    assign alu_cout = M ? 1'b0 : arith_sum[8];

    assign dbus = SBUS ? SD : MBUS ? mem_q[ar_q] : ABUS ? alu_f : 8'h00;
    assign multi_bus = (SBUS & MBUS) | (SBUS & ABUS) | (MBUS & ABUS);

    always_comb begin
        rf_d  = rf_q;
        pc_d  = pc_q;
        ar_d  = ar_q;
        ir_d  = ir_q;
        c_d   = c_q;
        z_d   = z_q;
        w_d   = w_q;
        run_d = run_q;
        be_d  = be_q;
        if (run_q) begin
            if (DRW) rf_d[sel_a] = dbus;
            if (LDC) c_d = alu_cout;
            if (LDZ) z_d = (alu_f == 8'h00);
            if (LIR) ir_d = mem_q[pc_q];
            if (LPC)        pc_d = AW'(dbus);
            else if (PCADD) pc_d = pc_q + AW'($signed(ir_q[3:0]));
            else if (PCINC) pc_d = pc_q + 1'b1;
            if (LAR)        ar_d = AW'(dbus);
            else if (ARINC) ar_d = ar_q + 1'b1;
            unique case (w_q)
                W1:      w_d = SHORT ? W1 : W2;
                W2:      w_d = LONG ? W3 : W1;
                default: w_d = W1;
            endcase
            if (multi_bus) be_d = 1'b1;
            if (STOP) run_d = 1'b0;
        end else if (START) begin
            run_d = 1'b1;
        end
    end

    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
            pc_q  <= '0;
            ar_q  <= '0;
            ir_q  <= 8'h00;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            w_q   <= W1;
            run_q <= 1'b0;
            be_q  <= 1'b0;
        end else begin
            rf_q  <= rf_d;
            pc_q  <= pc_d;
            ar_q  <= ar_d;
            ir_q  <= ir_d;
            c_q   <= c_d;
            z_q   <= z_d;
            w_q   <= w_d;
            run_q <= run_d;
            be_q  <= be_d;
        end
    end

    // run_q is forced low by CLR, so a write can never land while reset is held.
    always_ff @(posedge T3) begin
        if (run_q && MEMW) mem_q[ar_q] <= dbus;
    end

    assign IR      = ir_q[7:4];
    assign C       = c_q;
    assign Z       = z_q;
    assign W       = w_q;
    assign DBUS    = dbus;
    assign PC_O    = pc_q;
    assign AR_O    = ar_q;
    assign RUN     = run_q;
    assign BUS_ERR = be_q;

endmodule
